// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor
//   Receive-side checker for a VGA conduit stream (HS/VS/BLANK + 8-bit RGB). Measures line and
//   frame geometry against the expected timing parameters and accumulates a per-frame pixel
//   signature. It reports lock and error status. It never drives the display.
//
// Ports
//   clk_clk                  pixel clock, one pixel per cycle
//   reset_reset_n            asynchronous active-low reset
//   vga_hs_n, vga_vs_n       active-low syncs
//   vga_blank_n              high marks an active pixel
//   vga_r, vga_g, vga_b      pixel colour
//   clear_err                synchronous clear of timing_err / err_count (wins over an increment)
//   locked                   high after two consecutive good frames
//   frame_done               one-cycle pulse when the frame outputs update
//   meas_h_total/active      geometry of the last closed line
//   meas_v_total/active      geometry of the last closed frame
//   frame_sig                pixel signature of the last closed frame
//   frame_count              complete frames seen, wrapping
//   err_count                bad frames seen, saturating
//   timing_err               sticky bad-frame flag
module vga_stream_monitor #(
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_TOTAL  = 525,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        vga_hs_n,
   input  logic        vga_vs_n,
   input  logic        vga_blank_n,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   input  logic        clear_err,
   output logic        locked,
   output logic        frame_done,
   output logic [11:0] meas_h_total,
   output logic [11:0] meas_h_active,
   output logic [11:0] meas_v_total,
   output logic [11:0] meas_v_active,
   output logic [31:0] frame_sig,
   output logic [15:0] frame_count,
   output logic [15:0] err_count,
   output logic        timing_err
);

   localparam logic [11:0] HTotal  = 12'(H_TOTAL);
   localparam logic [11:0] HActive = 12'(H_ACTIVE);
   localparam logic [11:0] VTotal  = 12'(V_TOTAL);
   localparam logic [11:0] VActive = 12'(V_ACTIVE);

   typedef enum logic [1:0] {StAcquire, StFirst, StTrack, StLocked} state_e;

   state_e state_q;

   // Input pipeline. Only the syncs need the second stage for edge detection; colour and
   // blank are consumed at s1 so they line up with the detected edges.
   logic        hs_s1, hs_s2, vs_s1, vs_s2;
   logic        blank_s1;
   logic [23:0] pix_s1;

   logic [11:0] h_cnt_q, h_act_q, v_cnt_q, v_act_q;
   logic        frame_bad_q;
   logic [31:0] sig_q;

   logic        line_edge, frame_edge;
   logic        line_active, line_bad;
   logic [11:0] v_act_closed;
   logic        bad_closed, frame_good, frame_err;
   logic [31:0] sig_step;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   always_comb begin
      line_edge    = ~hs_s1 & hs_s2;
      frame_edge   = ~vs_s1 & vs_s2;
      line_active  = (h_act_q != 12'd0);
      line_bad     = (h_cnt_q != HTotal) || (line_active && (h_act_q != HActive));
      // A line closed by an edge coincident with the frame edge still belongs to the old frame.
      v_act_closed = (line_edge && line_active) ? sat_inc(v_act_q) : v_act_q;
      bad_closed   = frame_bad_q | (line_edge & line_bad);
      frame_good   = (v_cnt_q == VTotal) && (v_act_closed == VActive) && !bad_closed;
      frame_err    = frame_edge && (state_q != StAcquire) && !frame_good;
      sig_step     = {sig_q[30:0], sig_q[31]} ^ {8'h00, pix_s1};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         // Syncs reset high so release never looks like a falling edge.
         hs_s1         <= 1'b1;
         hs_s2         <= 1'b1;
         vs_s1         <= 1'b1;
         vs_s2         <= 1'b1;
         blank_s1      <= 1'b0;
         pix_s1        <= 24'h0;
         h_cnt_q       <= 12'd0;
         h_act_q       <= 12'd0;
         v_cnt_q       <= 12'd0;
         v_act_q       <= 12'd0;
         frame_bad_q   <= 1'b0;
         sig_q         <= 32'h0;
         state_q       <= StAcquire;
         locked        <= 1'b0;
         frame_done    <= 1'b0;
         meas_h_total  <= 12'd0;
         meas_h_active <= 12'd0;
         meas_v_total  <= 12'd0;
         meas_v_active <= 12'd0;
         frame_sig     <= 32'h0;
         frame_count   <= 16'd0;
         err_count     <= 16'd0;
         timing_err    <= 1'b0;
      end else begin
         hs_s1    <= vga_hs_n;
         hs_s2    <= hs_s1;
         vs_s1    <= vga_vs_n;
         vs_s2    <= vs_s1;
         blank_s1 <= vga_blank_n;
         pix_s1   <= {vga_r, vga_g, vga_b};

         // Line geometry
         if (line_edge) begin
            meas_h_total  <= h_cnt_q;
            meas_h_active <= h_act_q;
            h_cnt_q       <= 12'd1;
            h_act_q       <= {11'd0, blank_s1};
         end else begin
            h_cnt_q <= sat_inc(h_cnt_q);
            if (blank_s1) begin
               h_act_q <= sat_inc(h_act_q);
            end
         end

         // Frame geometry
         if (frame_edge) begin
            v_cnt_q     <= line_edge ? 12'd1 : 12'd0;
            v_act_q     <= 12'd0;
            frame_bad_q <= 1'b0;
         end else if (line_edge) begin
            v_cnt_q     <= sat_inc(v_cnt_q);
            v_act_q     <= v_act_closed;
            frame_bad_q <= bad_closed;
         end

         // Signature
         if (frame_edge) begin
            sig_q <= blank_s1 ? {8'h00, pix_s1} : 32'h0;
         end else if (blank_s1) begin
            sig_q <= sig_step;
         end

         // Lock FSM and frame outputs
         frame_done <= 1'b0;
         if (frame_edge) begin
            unique case (state_q)
               StAcquire: state_q <= StFirst;
               StFirst:   state_q <= frame_good ? StTrack  : StFirst;
               StTrack:   state_q <= frame_good ? StLocked : StFirst;
               StLocked:  state_q <= frame_good ? StLocked : StFirst;
               default:   state_q <= StAcquire;
            endcase
            locked <= frame_good && ((state_q == StTrack) || (state_q == StLocked));
            if (state_q != StAcquire) begin
               frame_done    <= 1'b1;
               frame_count   <= frame_count + 16'd1;
               meas_v_total  <= v_cnt_q;
               meas_v_active <= v_act_closed;
               frame_sig     <= sig_q;
            end
         end

         if (clear_err) begin
            err_count  <= 16'd0;
            timing_err <= 1'b0;
         end else if (frame_err) begin
            err_count  <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            timing_err <= 1'b1;
         end
      end
   end

endmodule
